// File: rtl/sim_run_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sim_run_controller                                         |
// | Description : Run controller for the RISC-V core. It sequences the core  |
// |               reset, counts RUN cycles and retired instructions, detects |
// |               end-of-test from a riscv-tests style tohost store, applies |
// |               a cycle timeout and freezes the core once the run is done. |
// | Options     : SIM_CONSOLE_EN adds a byte console at TOHOST_ADDR+4.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module sim_run_controller #(
    parameter int                RST_CYCLES     = 2,
    parameter int                TIMEOUT_CYCLES = 30,
    parameter int                CNT_W          = 32,
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 'h0000_0FFC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              retire,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [DATA_W-2:0] exit_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instret_count
`ifdef SIM_CONSOLE_EN
    ,
    output logic              console_valid,
    output logic [7:0]        console_char
`endif
);

    // Hold counter needs at least one bit even when RST_CYCLES is 1.
    localparam int                HOLD_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD    = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESET_HOLD = 2'd1,
        RUN        = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_next;
    logic                core_reset_next;
    logic                busy_next;
    logic                done_next;
    logic                pass_next;
    logic                fail_next;
    logic                timeout_next;
    logic [DATA_W-2:0]   exit_code_next;
    logic [CNT_W-1:0]    cycle_next;
    logic [CNT_W-1:0]    instret_next;

    // A tohost store only ends the test when bit 0 (the "done" marker) is set.
    logic                tohost_hit;
    logic [DATA_W-2:0]   tohost_code;
    logic [CNT_W-1:0]    cycle_inc;
    logic [CNT_W-1:0]    instret_inc;

    assign tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
    assign tohost_code = mem_wdata[DATA_W-1:1];

    // Counters saturate rather than wrap so a long run never reads as short.
    assign cycle_inc   = (cycle_count   == CNT_MAX) ? cycle_count   : cycle_count   + CNT_W'(1);
    assign instret_inc = (instret_count == CNT_MAX) ? instret_count : instret_count + CNT_W'(1);

    // State and all registered outputs; reset parks the core in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            core_reset    <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            timeout       <= 1'b0;
            exit_code     <= '0;
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            state         <= state_next;
            hold_cnt      <= hold_next;
            core_reset    <= core_reset_next;
            busy          <= busy_next;
            done          <= done_next;
            pass          <= pass_next;
            fail          <= fail_next;
            timeout       <= timeout_next;
            exit_code     <= exit_code_next;
            cycle_count   <= cycle_next;
            instret_count <= instret_next;
        end
    end

    // Next-state and next-output logic; everything holds unless changed below.
    always_comb begin
        state_next      = state;
        hold_next       = hold_cnt;
        core_reset_next = core_reset;
        busy_next       = busy;
        done_next       = done;
        pass_next       = pass;
        fail_next       = fail;
        timeout_next    = timeout;
        exit_code_next  = exit_code;
        cycle_next      = cycle_count;
        instret_next    = instret_count;

        case (state)
            IDLE, DONE: begin
                // A new run starts from a clean slate, whether idle or finished.
                if (start) begin
                    state_next      = RESET_HOLD;
                    hold_next       = HOLD_LOAD;
                    core_reset_next = 1'b1;
                    busy_next       = 1'b1;
                    done_next       = 1'b0;
                    pass_next       = 1'b0;
                    fail_next       = 1'b0;
                    timeout_next    = 1'b0;
                    exit_code_next  = '0;
                    cycle_next      = '0;
                    instret_next    = '0;
                end
            end

            RESET_HOLD: begin
                // core_reset drops on the same edge that enters RUN.
                if (hold_cnt == '0) begin
                    state_next      = RUN;
                    core_reset_next = 1'b0;
                end else begin
                    hold_next = hold_cnt - HOLD_W'(1);
                end
            end

            RUN: begin
                // Counters advance on every RUN edge, including the final one.
                cycle_next = cycle_inc;
                if (retire) begin
                    instret_next = instret_inc;
                end

                // tohost takes priority over a timeout landing on the same edge.
                if (tohost_hit) begin
                    state_next      = DONE;
                    core_reset_next = 1'b1;
                    busy_next       = 1'b0;
                    done_next       = 1'b1;
                    exit_code_next  = tohost_code;
                    pass_next       = (tohost_code == '0);
                    fail_next       = (tohost_code != '0);
                end else if (cycle_count == TIMEOUT_LAST) begin
                    state_next      = DONE;
                    core_reset_next = 1'b1;
                    busy_next       = 1'b0;
                    done_next       = 1'b1;
                    timeout_next    = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef SIM_CONSOLE_EN
    localparam logic [ADDR_W-1:0] CONSOLE_ADDR = TOHOST_ADDR + ADDR_W'(4);

    logic console_hit;

    assign console_hit = (state == RUN) && mem_we && (mem_addr == CONSOLE_ADDR);

    // One-cycle character strobe per console store made during RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            console_valid <= 1'b0;
            console_char  <= 8'h00;
        end else begin
            console_valid <= console_hit;
            if (console_hit) begin
                console_char <= mem_wdata[7:0];
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sim_run_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sim_run_controller                                      |
// | Description : Self-checking bench for sim_run_controller. Each run is    |
// |               described as a plan (tohost cycle, exit code, retire       |
// |               pattern, noise) and the expected end state is computed     |
// |               from that plan. SIM_CONSOLE_EN enables the console steps.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_sim_run_controller;

    localparam int          RST_CYCLES     = 2;
    localparam int          TIMEOUT_CYCLES = 30;
    localparam int          CNT_W          = 32;
    localparam int          ADDR_W         = 32;
    localparam int          DATA_W         = 32;
    localparam logic [31:0] TOHOST         = 32'h0000_0FFC;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              mem_we = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [DATA_W-1:0] mem_wdata = '0;
    logic              retire = 1'b0;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [DATA_W-2:0] exit_code;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  instret_count;
`ifdef SIM_CONSOLE_EN
    logic              console_valid;
    logic [7:0]        console_char;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sim_run_controller #(
        .RST_CYCLES     (RST_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TOHOST_ADDR    (TOHOST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .retire        (retire),
        .core_reset    (core_reset),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail          (fail),
        .timeout       (timeout),
        .exit_code     (exit_code),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
`ifdef SIM_CONSOLE_EN
        ,
        .console_valid (console_valid),
        .console_char  (console_char)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        start     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".core_reset"}, 64'(core_reset), 64'd1);
        chk({tag, ".busy"},       64'(busy),       64'd0);
        chk({tag, ".done"},       64'(done),       64'd0);
        chk({tag, ".pass"},       64'(pass),       64'd0);
        chk({tag, ".fail"},       64'(fail),       64'd0);
        chk({tag, ".timeout"},    64'(timeout),    64'd0);
        chk({tag, ".exit_code"},  64'(exit_code),  64'd0);
        chk({tag, ".cycles"},     64'(cycle_count),   64'd0);
        chk({tag, ".instret"},    64'(instret_count), 64'd0);
`ifdef SIM_CONSOLE_EN
        chk({tag, ".con_valid"},  64'(console_valid), 64'd0);
        chk({tag, ".con_char"},   64'(console_char),  64'd0);
`endif
    endtask

    // Start edge, then reset hold with garbage on the inputs; ends at RUN cycle 0.
    task automatic start_run(input string tag);
        start  = 1'b1;
        retire = 1'b1;
        tick();
        chk({tag, ".st_busy"},    64'(busy),          64'd1);
        chk({tag, ".st_corerst"}, 64'(core_reset),    64'd1);
        chk({tag, ".st_done"},    64'(done),          64'd0);
        chk({tag, ".st_flags"},   64'({pass, fail, timeout}), 64'd0);
        chk({tag, ".st_exit"},    64'(exit_code),     64'd0);
        chk({tag, ".st_cycles"},  64'(cycle_count),   64'd0);
        chk({tag, ".st_instret"}, 64'(instret_count), 64'd0);
        mem_we    = 1'b1;
        mem_addr  = TOHOST;
        mem_wdata = 32'h1;
        for (int h = 1; h < RST_CYCLES; h++) begin
            tick();
            chk({tag, ".hold_corerst"}, 64'(core_reset), 64'd1);
        end
        tick();
        chk({tag, ".run_corerst"}, 64'(core_reset),    64'd0);
        chk({tag, ".run_busy"},    64'(busy),          64'd1);
        chk({tag, ".run_done"},    64'(done),          64'd0);
        chk({tag, ".run_cycles"},  64'(cycle_count),   64'd0);
        chk({tag, ".run_instret"}, 64'(instret_count), 64'd0);
        drive_idle();
    endtask

    // noise: 0 none, 1 deterministic by cycle index, 2 random (also toggles start).
    task automatic run_body(input string tag, input int hit_at, input logic [30:0] code,
                            input bit rand_retire, input logic [31:0] mask, input int noise);
        int          exp_inst;
        int          last;
        int          kind;
        int          exp_cycles;
        logic [31:0] tmp;
        bit          hit;
        exp_inst = 0;
        hit      = (hit_at < TIMEOUT_CYCLES);
        last     = hit ? hit_at : TIMEOUT_CYCLES - 1;
        for (int i = 0; i <= last; i++) begin
            chk({tag, ".cyc_idx"}, 64'(cycle_count), 64'(i));
            retire = rand_retire ? 1'($urandom_range(0, 1)) : mask[i];
            if (retire) exp_inst++;
            start  = (noise == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_we = 1'b0;
            if (i == hit_at) begin
                mem_we    = 1'b1;
                mem_addr  = TOHOST;
                mem_wdata = {code, 1'b1};
            end else if (noise != 0) begin
                kind = (noise == 1) ? (i % 4) : int'($urandom_range(0, 3));
                tmp  = $urandom;
                case (kind)
                    1: begin
                        tmp[0]    = 1'b0;
                        mem_we    = 1'b1;
                        mem_addr  = TOHOST;
                        mem_wdata = (noise == 1) ? 32'h6 : tmp;
                    end
                    2: begin
                        mem_we    = 1'b1;
                        mem_addr  = TOHOST - 32'd4;
                        mem_wdata = 32'h1;
                    end
                    3: begin
                        tmp[0]    = 1'b1;
                        mem_we    = 1'b0;
                        mem_addr  = TOHOST;
                        mem_wdata = tmp;
                    end
                    default: begin
                        tmp[0]    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = 32'h0000_1000;
                        mem_wdata = tmp;
                    end
                endcase
            end
            tick();
        end
        drive_idle();
        exp_cycles = hit ? hit_at + 1 : TIMEOUT_CYCLES;
        chk({tag, ".done"},       64'(done),       64'd1);
        chk({tag, ".busy"},       64'(busy),       64'd0);
        chk({tag, ".core_reset"}, 64'(core_reset), 64'd1);
        chk({tag, ".pass"},       64'(pass),       64'(hit && code == 0));
        chk({tag, ".fail"},       64'(fail),       64'(hit && code != 0));
        chk({tag, ".timeout"},    64'(timeout),    64'(!hit));
        chk({tag, ".exit_code"},  64'(exit_code),  hit ? 64'(code) : 64'd0);
        chk({tag, ".cycles"},     64'(cycle_count),   64'(exp_cycles));
        chk({tag, ".instret"},    64'(instret_count), 64'(exp_inst));
        // DONE must ignore bus activity and retire pulses.
        mem_we    = 1'b1;
        mem_addr  = TOHOST;
        mem_wdata = 32'h3;
        retire    = 1'b1;
        tick();
        tick();
        drive_idle();
        chk({tag, ".hold_done"},    64'(done),          64'd1);
        chk({tag, ".hold_flags"},   64'({pass, fail, timeout}),
            64'({hit && code == 0, hit && code != 0, !hit}));
        chk({tag, ".hold_cycles"},  64'(cycle_count),   64'(exp_cycles));
        chk({tag, ".hold_instret"}, 64'(instret_count), 64'(exp_inst));
    endtask

    initial begin
        int          hit_at;
        logic [30:0] code;

        // Reset held for two cycles.
        drive_idle();
        reset = 1'b0;
        tick();
        tick();
        check_reset_values("rst");
        reset = 1'b1;
        tick();
        chk("idle.core_reset", 64'(core_reset), 64'd1);
        chk("idle.busy",       64'(busy),       64'd0);

        // Pass at RUN cycle 10 with 7 retire pulses.
        start_run("pass");
        run_body("pass", 10, 31'd0, 1'b0, 32'h0000_007F, 0);

        // Fail with code 3 after ignored tohost/neighbour stores.
        start_run("fail");
        run_body("fail", 12, 31'd3, 1'b0, 32'h0000_0F0F, 1);

        // Timeout with random retire and noise.
        start_run("tmo");
        run_body("tmo", 99, 31'd0, 1'b1, 32'h0, 2);

        // tohost on the timeout cycle wins.
        start_run("tie");
        run_body("tie", TIMEOUT_CYCLES - 1, 31'd0, 1'b1, 32'h0, 2);

        // Random runs, each restarted from DONE.
        for (int r = 0; r < 6; r++) begin
            hit_at = int'($urandom_range(0, TIMEOUT_CYCLES + 8));
            code   = ($urandom_range(0, 2) == 0) ? 31'd0 : 31'($urandom);
            start_run("rnd");
            run_body("rnd", hit_at, code, 1'b1, 32'h0, 2);
        end

`ifdef SIM_CONSOLE_EN
        // Back-to-back console characters, then finish with a pass.
        start_run("con");
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_1000;
        mem_wdata = 32'h48;
        tick();
        chk("con.valid_h", 64'(console_valid), 64'd1);
        chk("con.char_h",  64'(console_char),  64'h48);
        mem_wdata = 32'h69;
        tick();
        chk("con.valid_i", 64'(console_valid), 64'd1);
        chk("con.char_i",  64'(console_char),  64'h69);
        drive_idle();
        tick();
        chk("con.valid_off", 64'(console_valid), 64'd0);
        mem_we    = 1'b1;
        mem_addr  = TOHOST;
        mem_wdata = 32'h1;
        tick();
        drive_idle();
        chk("con.done",   64'(done),        64'd1);
        chk("con.pass",   64'(pass),        64'd1);
        chk("con.cycles", 64'(cycle_count), 64'd4);
`endif

        // Asynchronous reset in the middle of a run.
        start_run("mid");
        retire = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        retire = 1'b0;
        chk("mid.cycles_before", 64'(cycle_count),   64'd5);
        chk("mid.instret_before", 64'(instret_count), 64'd5);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("mid");
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("mid.idle_busy",    64'(busy),        64'd0);
        chk("mid.idle_corerst", 64'(core_reset),  64'd1);
        chk("mid.idle_cycles",  64'(cycle_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
